// File: rtl/axi_if.sv
// AXI4-Lite bus bundle shared by the register-file slave and its master.
//   Params : ADDR_WIDTH (AWADDR/ARADDR width), DATA_WIDTH (WDATA/RDATA width)
//   Write  : AWVALID/AWADDR/AWREADY, WVALID/WDATA/WREADY, BVALID/BRESP/BREADY
//   Read   : ARVALID/ARADDR/ARREADY, RVALID/RDATA/RRESP/RREADY
//   Modports: master (drives requests), slave and DUT (identical, drive responses)
interface axi_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  AWVALID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWREADY;
  logic                  WVALID;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WREADY;
  logic                  BVALID;
  logic [1:0]            BRESP;
  logic                  BREADY;
  logic                  ARVALID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARREADY;
  logic                  RVALID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RREADY;

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport DUT (
    input  AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_slave.sv
// AXI4-Lite register file: NUM_REGS word registers behind independent write
// (AW/W/B) and read (AR/R) channels, one outstanding transaction per direction.
// Out-of-range word indices answer SLVERR; such writes are dropped, reads return 0.
//   ACLK    : clock, all state updates on the rising edge
//   ARESETN : asynchronous active-low reset
//   bus     : axi_if DUT modport carrying all five AXI-Lite channels
module axi_lite_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input logic ACLK,
  input logic ARESETN,
  axi_if.DUT  bus
);

  localparam int unsigned RegIdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  // Word index is the byte address with the two byte-lane bits dropped.
  function automatic logic in_range(input logic [ADDR_WIDTH-3:0] word_idx);
    return 64'(word_idx) < 64'(NUM_REGS);
  endfunction

  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  awready, wready, arready;
  logic                  wr_ok, rd_ok;
  logic [RegIdxW-1:0]    wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_addr_lsbs;

  // READYs derive only from registered state (and reset), never from VALIDs.
  assign awready = ARESETN & ~aw_held_q & ~bvalid_q;
  assign wready  = ARESETN & ~w_held_q  & ~bvalid_q;
  assign arready = ARESETN & ~rvalid_q;

  assign wr_ok   = in_range(awaddr_q[ADDR_WIDTH-1:2]);
  assign rd_ok   = in_range(bus.ARADDR[ADDR_WIDTH-1:2]);
  assign wr_idx  = awaddr_q[RegIdxW+1:2];
  assign rd_idx  = bus.ARADDR[RegIdxW+1:2];
  assign rd_word = rd_ok ? regs_q[rd_idx] : '0;

  assign unused_addr_lsbs = ^{awaddr_q[1:0], bus.ARADDR[1:0]};

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  // Write channel: collect AW and W in any order, commit once both are held.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (bvalid_q && bus.BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (aw_held_q && w_held_q) begin
        // Both READYs are low here, so no new handshake can collide with the commit.
        if (wr_ok) begin
          regs_q[wr_idx] <= wdata_q;
        end
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? RespOkay : RespSlvErr;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end else begin
        if (bus.AWVALID && awready) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= bus.AWADDR;
        end
        if (bus.WVALID && wready) begin
          w_held_q <= 1'b1;
          wdata_q  <= bus.WDATA;
        end
      end
    end
  end

  // Read channel: data is captured on the AR handshake edge. A commit on the
  // same edge is not yet visible, so the pre-write value is returned.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else if (bus.ARVALID && arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= rd_ok ? RespOkay : RespSlvErr;
    end else if (rvalid_q && bus.RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave.sv
module tb_axi_lite_slave;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic ACLK;
  logic ARESETN;

  axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (16)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [1:0] bq [$];
  rexp_t      rq [$];
  logic [31:0] model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Scoreboard monitor: a VALID&READY seen at the falling edge completes at the
  // next rising edge, so each response is popped exactly once.
  always @(negedge ACLK) begin
    if (ARESETN && bus.BVALID && bus.BREADY) begin
      if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
      else check("bresp", 32'(bus.BRESP), 32'(bq.pop_front()));
    end
    if (ARESETN && bus.RVALID && bus.RREADY) begin
      if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
      else begin
        rexp_t e;
        e = rq.pop_front();
        check("rdata", bus.RDATA, e.data);
        check("rresp", 32'(bus.RRESP), 32'(e.resp));
      end
    end
  end

  // Called just after a rising edge; returns at the falling edge where BVALID is seen.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int c = 0, lat = 0;
    bq.push_back(resp);
    if (resp == 2'b00) model[addr[5:2]] = data;
    while (!(aw_done && w_done)) begin
      if (c == aw_dly) begin bus.AWVALID = 1'b1; bus.AWADDR = addr; end
      if (c == w_dly)  begin bus.WVALID  = 1'b1; bus.WDATA  = data; end
      @(negedge ACLK);
      if (w_done && !aw_done) check("wready_held", 32'(bus.WREADY), 32'd0);
      if (aw_done && !w_done) check("awready_held", 32'(bus.AWREADY), 32'd0);
      aw_fire = bus.AWVALID && bus.AWREADY;
      w_fire  = bus.WVALID && bus.WREADY;
      @(posedge ACLK); #1;
      if (aw_fire) begin bus.AWVALID = 1'b0; aw_done = 1; end
      if (w_fire)  begin bus.WVALID  = 1'b0; w_done  = 1; end
      c++;
      if (c > 50) begin check("write_hs_timeout", 32'd1, 32'd0); break; end
    end
    forever begin
      @(negedge ACLK);
      if (bus.BVALID) break;
      lat++;
      if (lat > 10) break;
    end
    check("b_latency", 32'(lat), 32'd1);
  endtask

  // Called just after a rising edge; returns at the falling edge after the AR handshake.
  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    rexp_t e;
    bit fire;
    int c = 0;
    e.data = exp_data;
    e.resp = exp_resp;
    rq.push_back(e);
    bus.ARVALID = 1'b1;
    bus.ARADDR  = addr;
    forever begin
      @(negedge ACLK);
      fire = bus.ARREADY;
      @(posedge ACLK); #1;
      if (fire) begin bus.ARVALID = 1'b0; break; end
      c++;
      if (c > 50) begin check("read_hs_timeout", 32'd1, 32'd0); bus.ARVALID = 1'b0; break; end
    end
    @(negedge ACLK);
    check("r_latency", 32'(bus.RVALID), 32'd1);
  endtask

  task automatic wait_b_done();
    int n = 0;
    while (bq.size() != 0 && n < 20) begin @(negedge ACLK); n++; end
    if (bq.size() != 0) check("b_timeout", 32'(bq.size()), 32'd0);
    @(posedge ACLK); #1;
  endtask

  task automatic wait_r_done();
    int n = 0;
    while (rq.size() != 0 && n < 20) begin @(negedge ACLK); n++; end
    if (rq.size() != 0) check("r_timeout", 32'(rq.size()), 32'd0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    ARESETN     = 1'b0;
    bus.AWVALID = 1'b0; bus.AWADDR = '0;
    bus.WVALID  = 1'b0; bus.WDATA  = '0;
    bus.BREADY  = 1'b1;
    bus.ARVALID = 1'b0; bus.ARADDR = '0;
    bus.RREADY  = 1'b1;

    // Reset: everything low while held, READYs high once released.
    repeat (5) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 32'(bus.AWREADY), 32'd0);
    check("rst_wready",  32'(bus.WREADY),  32'd0);
    check("rst_arready", 32'(bus.ARREADY), 32'd0);
    check("rst_bvalid",  32'(bus.BVALID),  32'd0);
    check("rst_rvalid",  32'(bus.RVALID),  32'd0);
    check("rst_resps",   32'({bus.BRESP, bus.RRESP}), 32'd0);
    check("rst_rdata",   bus.RDATA, 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("post_rst_readys", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'b111);
    check("post_rst_valids", 32'({bus.BVALID, bus.RVALID}), 32'd0);
    @(posedge ACLK); #1;

    // Basic write and read-back.
    axi_write(32'h04, 32'hDEADBEEF, 2'b00, 0, 0);
    wait_b_done();
    axi_read(32'h04, 32'hDEADBEEF, 2'b00);
    wait_r_done();

    // W three cycles ahead of AW.
    axi_write(32'h08, 32'h12345678, 2'b00, 3, 0);
    wait_b_done();
    axi_read(32'h08, 32'h12345678, 2'b00);
    wait_r_done();

    // B backpressure: response and READYs must hold still.
    bus.BREADY = 1'b0;
    axi_write(32'h10, 32'hCAFE0011, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("bp_bvalid",  32'(bus.BVALID),  32'd1);
      check("bp_bresp",   32'(bus.BRESP),   32'd0);
      check("bp_awready", 32'(bus.AWREADY), 32'd0);
    end
    @(posedge ACLK); #1;
    bus.BREADY = 1'b1;
    wait_b_done();

    // R backpressure.
    bus.RREADY = 1'b0;
    axi_read(32'h10, 32'hCAFE0011, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("bp_rvalid",  32'(bus.RVALID),  32'd1);
      check("bp_rdata",   bus.RDATA,        32'hCAFE0011);
      check("bp_arready", 32'(bus.ARREADY), 32'd0);
    end
    @(posedge ACLK); #1;
    bus.RREADY = 1'b1;
    wait_r_done();

    // Out of range (index 16).
    axi_write(32'h40, 32'hFFFFFFFF, 2'b10, 0, 0);
    wait_b_done();
    axi_read(32'h40, 32'h0, 2'b10);
    wait_r_done();

    // Byte-lane bits ignored; later write overwrites.
    axi_write(32'h0E, 32'hA5A5A5A5, 2'b00, 0, 0);
    wait_b_done();
    axi_write(32'h0C, 32'h5A5A5A5A, 2'b00, 1, 0);
    wait_b_done();
    axi_read(32'h0F, 32'h5A5A5A5A, 2'b00);
    wait_r_done();

    // Whole register file: only indices 1, 2, 3, 4 were written.
    for (int i = 0; i < 16; i++) begin
      axi_read(32'(i * 4), model[i], 2'b00);
      wait_r_done();
    end

    check("bq_drained", 32'(bq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
